// File: rtl/axis_beat_packer.sv
// axis_beat_packer: gathers RATIO narrow AXI-Stream beats into one wide word,
// frames every PKT_WORDS words into a packet with tlast, and supports a flush
// pulse that emits a partial word and closes the packet early.
module axis_beat_packer #(
  parameter int DATA_WIDTH = 4,
  parameter int RATIO      = 4,
  parameter int PKT_WORDS  = 8
) (
  input  logic                          axis_clk,
  input  logic                          axis_rst,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          flush,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DATA_WIDTH*RATIO-1:0]   m_axis_tdata,
  output logic [RATIO-1:0]              m_axis_tkeep,
  output logic                          m_axis_tlast
);

  localparam int BW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int WW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam int OW = DATA_WIDTH * RATIO;
  localparam int AW = DATA_WIDTH * (RATIO - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(RATIO - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(PKT_WORDS - 1);

  logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [WW-1:0]    word_cnt_q, word_cnt_d;
  logic             flush_pend_q, flush_pend_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic             m_valid_q, m_valid_d;
  logic [OW-1:0]    m_data_q, m_data_d;
  logic [RATIO-1:0] m_keep_q, m_keep_d;
  logic             m_last_q, m_last_d;

  logic slot_free;
  logic s_ready;
  logic beat_hs;
  logic word_done;
  logic flush_emit;

  // Handshake qualifiers: the last lane only enters when the output slot can
  // take the finished word, and intake freezes while a partial word awaits flush.
  always_comb begin
    slot_free  = !m_valid_q || m_axis_tready;
    s_ready    = !axis_rst && ((beat_cnt_q < BEAT_LAST) || slot_free) &&
                 !(flush_pend_q && (beat_cnt_q != '0));
    beat_hs    = s_axis_tvalid && s_ready;
    word_done  = beat_hs && (beat_cnt_q == BEAT_LAST);
    flush_emit = flush_pend_q && (beat_cnt_q != '0) && slot_free;
  end

  // Next-state: accumulate lanes, load the output register on a full or
  // flushed word, and track packet position and pending flush.
  always_comb begin
    logic last_w;
    beat_cnt_d   = beat_cnt_q;
    word_cnt_d   = word_cnt_q;
    flush_pend_d = flush_pend_q;
    acc_d        = acc_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_keep_d     = m_keep_q;
    m_last_d     = m_last_q;
    last_w       = 1'b0;

    if (m_valid_q && m_axis_tready) m_valid_d = 1'b0;

    if (word_done) begin
      // A flush landing on the final beat closes the packet on this word.
      last_w     = (word_cnt_q == WORD_LAST) || flush;
      m_valid_d  = 1'b1;
      m_data_d   = {s_axis_tdata, acc_q};
      m_keep_d   = '1;
      m_last_d   = last_w;
      word_cnt_d = last_w ? '0 : word_cnt_q + 1'b1;
      beat_cnt_d = '0;
      acc_d      = '0;
    end else if (flush_emit) begin
      // acc is cleared after every word, so unfilled lanes are already zero.
      m_valid_d  = 1'b1;
      m_data_d   = {{DATA_WIDTH{1'b0}}, acc_q};
      for (int k = 0; k < RATIO; k++) m_keep_d[k] = (BW'(k) < beat_cnt_q);
      m_last_d     = 1'b1;
      word_cnt_d   = '0;
      beat_cnt_d   = '0;
      acc_d        = '0;
      flush_pend_d = 1'b0;
    end else if (beat_hs) begin
      for (int k = 0; k < RATIO - 1; k++) begin
        if (beat_cnt_q == BW'(k)) acc_d[k*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
      end
      beat_cnt_d = beat_cnt_q + 1'b1;
    end

    // A flush with nothing accumulated has nothing to emit.
    if (flush_pend_q && (beat_cnt_q == '0)) flush_pend_d = 1'b0;
    if (flush && !word_done) flush_pend_d = 1'b1;
  end

  // State registers; reset drops any partial word and any held output word.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      beat_cnt_q   <= '0;
      word_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
      acc_q        <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_keep_q     <= '0;
      m_last_q     <= 1'b0;
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      word_cnt_q   <= word_cnt_d;
      flush_pend_q <= flush_pend_d;
      acc_q        <= acc_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_keep_q     <= m_keep_d;
      m_last_q     <= m_last_d;
    end
  end

  assign s_axis_tready = s_ready;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tlast  = m_last_q;

endmodule

// File: tb/tb_axis_beat_packer.sv
// Testbench for axis_beat_packer: directed steps plus a random phase, with a
// transaction-level model feeding an expected-word queue.
module tb_axis_beat_packer;
  localparam int DW = 4;
  localparam int R  = 4;
  localparam int PW = 8;

  logic            axis_clk = 1'b0;
  logic            axis_rst;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic [DW-1:0]   s_axis_tdata;
  logic            flush;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic [DW*R-1:0] m_axis_tdata;
  logic [R-1:0]    m_axis_tkeep;
  logic            m_axis_tlast;

  always #5 axis_clk = ~axis_clk;

  axis_beat_packer #(.DATA_WIDTH(DW), .RATIO(R), .PKT_WORDS(PW)) dut (
    .axis_clk      (axis_clk),
    .axis_rst      (axis_rst),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .flush         (flush),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast)
  );

  typedef struct packed {
    logic [DW*R-1:0] d;
    logic [R-1:0]    k;
    logic            l;
  } word_t;

  word_t           exp_q[$];
  int              checks = 0;
  int              errors = 0;
  int              mcnt = 0;
  int              mwc = 0;
  logic [DW*R-1:0] macc = '0;
  logic            s_hs = 1'b0;
  logic            hold_pend = 1'b0;
  word_t           hold_w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge (inputs are stable until the next
  // rising edge), score output handshakes, advance the model, then step past
  // the rising edge.
  task automatic tick();
    word_t got;
    word_t e;
    @(negedge axis_clk);
    s_hs = 1'b0;
    if (axis_rst) begin
      exp_q.delete();
      mcnt = 0; mwc = 0; macc = '0; hold_pend = 1'b0;
    end else begin
      got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
      if (hold_pend) begin
        chk("hold_valid", 32'(m_axis_tvalid), 32'd1);
        chk("hold_word", 32'(got), 32'(hold_w));
      end
      hold_pend = m_axis_tvalid && !m_axis_tready;
      hold_w    = got;
      if (m_axis_tvalid && m_axis_tready) begin
        chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_word", 32'(got), 32'(e));
        end
      end
      s_hs = s_axis_tvalid && s_axis_tready;
      if (s_hs) begin
        macc[mcnt*DW +: DW] = s_axis_tdata;
        mcnt++;
        if (mcnt == R) begin
          e = {macc, {R{1'b1}}, ((mwc == PW-1) || flush)};
          exp_q.push_back(e);
          mwc  = e.l ? 0 : mwc + 1;
          mcnt = 0;
          macc = '0;
        end
      end
      if (flush && mcnt != 0) begin
        e = {macc, R'((1 << mcnt) - 1), 1'b1};
        exp_q.push_back(e);
        mwc = 0; mcnt = 0; macc = '0;
      end
    end
    @(posedge axis_clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic fl);
    int n;
    n = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    flush         = fl;
    do begin
      tick();
      flush = 1'b0;
      n++;
    end while (!s_hs && n < 100);
    if (!s_hs) chk("send_timeout", 32'(s_hs), 32'd1);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic drain(input int n);
    int c;
    c = 0;
    m_axis_tready = 1'b1;
    while (exp_q.size() != 0 && c < n) begin
      tick();
      c++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int sent;
    int cyc;
    axis_rst      = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = '0;
    flush         = 1'b0;
    m_axis_tready = 1'b1;

    // T1 reset
    repeat (3) tick();
    chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_m_tdata",  32'(m_axis_tdata),  32'd0);
    chk("rst_m_tkeep",  32'(m_axis_tkeep),  32'd0);
    chk("rst_m_tlast",  32'(m_axis_tlast),  32'd0);
    axis_rst      = 1'b0;
    s_axis_tvalid = 1'b0;
    tick();

    // T2 pack one word, check latency
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    chk("t2_valid_early", 32'(m_axis_tvalid), 32'd0);
    send(4'h4, 1'b0);
    chk("t2_valid", 32'(m_axis_tvalid), 32'd1);
    chk("t2_data",  32'(m_axis_tdata),  32'h4321);
    chk("t2_keep",  32'(m_axis_tkeep),  32'hF);
    chk("t2_last",  32'(m_axis_tlast),  32'd0);
    drain(20);

    // Mid-word reset discards the partial word
    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    axis_rst = 1'b1;
    tick();
    axis_rst = 1'b0;
    chk("midrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);

    // T3 full packet of 8 words, then word 9 starts a new packet
    for (int i = 0; i < 36; i++) send(DW'(i), 1'b0);
    drain(50);

    // T4 back-pressure
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 7; i++) send(DW'(i), 1'b0);
    chk("t4_held_valid", 32'(m_axis_tvalid), 32'd1);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 4'h8;
    repeat (3) begin
      tick();
      chk("t4_stall", 32'(s_hs), 32'd0);
    end
    chk("t4_held_data", 32'(m_axis_tdata), 32'h4321);
    m_axis_tready = 1'b1;
    tick();
    chk("t4_accept", 32'(s_hs), 32'd1);
    s_axis_tvalid = 1'b0;
    chk("t4_next_data", 32'(m_axis_tdata), 32'h8765);
    drain(20);

    // T5 flush of a partial word
    send(4'hA, 1'b0);
    send(4'hB, 1'b0);
    pulse_flush();
    tick();
    chk("t5_valid", 32'(m_axis_tvalid), 32'd1);
    chk("t5_data",  32'(m_axis_tdata),  32'h00BA);
    chk("t5_keep",  32'(m_axis_tkeep),  32'h3);
    chk("t5_last",  32'(m_axis_tlast),  32'd1);
    for (int i = 1; i <= 4; i++) send(DW'(i), 1'b0);
    chk("t5_next_valid", 32'(m_axis_tvalid), 32'd1);
    chk("t5_next_last",  32'(m_axis_tlast),  32'd0);
    pulse_flush();
    repeat (3) tick();
    chk("t5_empty_flush", 32'(m_axis_tvalid), 32'd0);
    // flush coincident with the final beat, then with a middle beat
    for (int i = 1; i <= 3; i++) send(DW'(i), 1'b0);
    send(4'h4, 1'b1);
    chk("t5_exact_last", 32'(m_axis_tlast), 32'd1);
    chk("t5_exact_keep", 32'(m_axis_tkeep), 32'hF);
    send(4'h5, 1'b0);
    send(4'h6, 1'b1);
    drain(20);
    chk("t5_mid_data", 32'(m_axis_tdata), 32'h0065);
    chk("t5_mid_keep", 32'(m_axis_tkeep), 32'h3);

    // T6 random valid/ready on both sides
    sent = 0;
    cyc  = 0;
    s_axis_tvalid = 1'b0;
    while (sent < 10000 && cyc < 80000) begin
      if (!s_axis_tvalid) begin
        s_axis_tvalid = ($urandom_range(0, 3) != 0);
        s_axis_tdata  = DW'($urandom);
      end
      m_axis_tready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
      if (s_hs) begin
        sent++;
        s_axis_tvalid = 1'b0;
      end
    end
    s_axis_tvalid = 1'b0;
    chk("t6_beats", 32'(sent), 32'd10000);
    drain(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
